// File: rtl/sim_axi_master.sv
// Simulation AXI4 master: writes burst_count INCR bursts of address-pattern data, then optionally reads them back.
// Optional SIM_AXI_MASTER_RDCHECK_EN: also count RDATA mismatches against the expected pattern.
module sim_axi_master #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int IW = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [7:0]      burst_len,
  input  logic [15:0]     burst_count,
  input  logic            do_read,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_count,
  output logic [IW-1:0]   M_AXI_AWID,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWLOCK,
  output logic [3:0]      M_AXI_AWCACHE,
  output logic [2:0]      M_AXI_AWPROT,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [IW-1:0]   M_AXI_ARID,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic            M_AXI_ARLOCK,
  output logic [3:0]      M_AXI_ARCACHE,
  output logic [2:0]      M_AXI_ARPROT,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);
  localparam logic [2:0]    SIZE = 3'($clog2(DW/8));
  localparam logic [AW-1:0] STEP = AW'(DW/8);

  typedef enum logic [2:0] {S_IDLE, S_AWR, S_WDAT, S_BWAIT, S_AR, S_RDAT, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d, base_q, base_d;
  logic [7:0]    len_q, len_d, beat_q, beat_d;
  logic [15:0]   cnt_q, cnt_d, burst_q, burst_d, bcnt_q, bcnt_d, err_q, err_d;
  logic          rd_q, rd_d, busy_q, busy_d, done_q, done_d, bready_q, bready_d;

  logic          b_hs, r_hs, last_beat, data_bad;
  logic [63:0]   addr64;
  logic [DW-1:0] pattern;
  logic [2:0]    err_inc;
  logic [16:0]   err_sum;

  // One address register serves as AW/W address in the write phase and AR/expected address in the read phase.
  assign addr64    = 64'(cur_q);
  assign pattern   = {(DW/64){addr64}};
  assign last_beat = (beat_q == len_q);
  assign b_hs      = M_AXI_BVALID & bready_q;
  assign r_hs      = (state_q == S_RDAT) & M_AXI_RVALID;

`ifdef SIM_AXI_MASTER_RDCHECK_EN
  assign data_bad = r_hs && (M_AXI_RDATA != pattern);
`else
  logic unused_rdata;
  assign unused_rdata = ^M_AXI_RDATA;
  assign data_bad     = 1'b0;
`endif

  assign err_inc = 3'(b_hs && (M_AXI_BRESP != 2'd0)) + 3'(r_hs && (M_AXI_RRESP != 2'd0))
                 + 3'(r_hs && (M_AXI_RLAST != last_beat)) + 3'(data_bad);
  assign err_sum = {1'b0, err_q} + 17'(err_inc);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    bcnt_d   = bcnt_q + 16'(b_hs);
    err_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    busy_d   = busy_q;
    done_d   = 1'b0;
    bready_d = 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        cur_d   = base_addr;
        base_d  = base_addr;
        len_d   = burst_len;
        cnt_d   = burst_count;
        rd_d    = do_read;
        beat_d  = '0;
        burst_d = '0;
        bcnt_d  = '0;
        err_d   = '0;
        busy_d  = 1'b1;
        state_d = (burst_count == 16'd0) ? S_FIN : S_AWR;
      end
      S_AWR: if (M_AXI_AWREADY) begin
        beat_d  = '0;
        state_d = S_WDAT;
      end
      S_WDAT: if (M_AXI_WREADY) begin
        cur_d = cur_q + STEP;
        if (last_beat) begin
          beat_d  = '0;
          burst_d = burst_q + 16'd1;
          state_d = (burst_q + 16'd1 == cnt_q) ? S_BWAIT : S_AWR;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      S_BWAIT: if (bcnt_q == cnt_q) begin
        cur_d   = base_q;
        burst_d = '0;
        state_d = rd_q ? S_AR : S_FIN;
      end
      S_AR: if (M_AXI_ARREADY) begin
        beat_d  = '0;
        state_d = S_RDAT;
      end
      S_RDAT: if (M_AXI_RVALID) begin
        cur_d = cur_q + STEP;
        if (last_beat) begin
          beat_d  = '0;
          burst_d = burst_q + 16'd1;
          state_d = (burst_q + 16'd1 == cnt_q) ? S_FIN : S_AR;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      beat_q   <= '0;
      burst_q  <= '0;
      bcnt_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      bcnt_q   <= bcnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bready_q <= bready_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_q;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = cur_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = SIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWVALID = (state_q == S_AWR);
  assign M_AXI_WDATA   = pattern;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = last_beat;
  assign M_AXI_WVALID  = (state_q == S_WDAT);
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = cur_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = SIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = (state_q == S_AR);
  assign M_AXI_RREADY  = (state_q == S_RDAT);
endmodule

// File: tb/tb_sim_axi_master.sv
// Bench for sim_axi_master: reactive AXI slave plus scoreboard queues checked by a negedge monitor.
module tb_sim_axi_master;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int IW = 4;
`ifdef SIM_AXI_MASTER_RDCHECK_EN
  localparam logic [15:0] CORR_ERR = 16'd1;
`else
  localparam logic [15:0] CORR_ERR = 16'd0;
`endif

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [15:0] err; int nb; } fin_t;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, do_read = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0] burst_len = '0;
  logic [15:0] burst_count = '0;
  logic busy, done;
  logic [15:0] err_count;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic [1:0] awburst, arburst, bresp = 2'd0, rresp = 2'd0;
  logic awlock, arlock, awvalid, wvalid, wlast, arvalid, bready, rready;
  logic [3:0] awcache, arcache;
  logic [DW-1:0] wdata, rdata = '0;
  logic [DW/8-1:0] wstrb;
  logic awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;

  int n_chk = 0, n_pass = 0;
  logic [63:0] aw_exp[$], ar_exp[$];
  beat_t w_exp[$], rq[$];
  logic [1:0] bq[$];
  fin_t fin_exp[$];
  bit stall = 0;
  int bad_b = -1, bad_r = -1, w_seen = 0;
  logic [7:0] cur_len = '0;

  always #5 clk = ~clk;

  sim_axi_master #(.DW(DW), .AW(AW), .IW(IW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .burst_count(burst_count), .do_read(do_read), .busy(busy), .done(done), .err_count(err_count),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    logic [DW-1:0] p;
    for (int i = 0; i < DW/64; i++) p[i*64 +: 64] = a;
    return p;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Slave model and monitor: decides READY/VALID at negedge, so handshakes seen here occur at the next posedge.
  initial begin : slave
    logic [63:0] aw_prev, a;
    logic [DW-1:0] w_prev;
    logic w_prev_last;
    bit aw_stall, w_stall, b_prev, r_prev;
    int wb_idx, r_idx, b_seen;
    beat_t bt;
    fin_t f;
    aw_prev = '0; w_prev = '0; w_prev_last = 0; aw_stall = 0; w_stall = 0;
    b_prev = 0; r_prev = 0; wb_idx = 0; r_idx = 0; b_seen = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0; bresp = 0;
        aw_stall = 0; w_stall = 0; b_prev = 0; r_prev = 0;
        wb_idx = 0; r_idx = 0; b_seen = 0; w_seen = 0;
        aw_exp.delete(); ar_exp.delete(); w_exp.delete(); rq.delete(); bq.delete(); fin_exp.delete();
      end else begin
        if (b_prev) bvalid = 0;
        if (r_prev) rvalid = 0;
        if (aw_stall) begin
          check("aw_hold_valid", awvalid, 1);
          check("aw_hold_addr", awaddr, aw_prev);
        end
        if (w_stall) begin
          check("w_hold_valid", wvalid, 1);
          check("w_hold_data", wdata, w_prev);
          check("w_hold_last", wlast, w_prev_last);
        end
        awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!bvalid && bq.size() > 0) begin bvalid = 1; bresp = bq.pop_front(); end
        if (!rvalid && rq.size() > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
          bt = rq.pop_front(); rdata = bt.data; rlast = bt.last; rresp = 0; rvalid = 1;
        end
        b_prev = bvalid && bready;
        r_prev = rvalid && rready;
        if (b_prev) b_seen++;
        aw_stall = awvalid && !awready; aw_prev = awaddr;
        w_stall = wvalid && !wready; w_prev = wdata; w_prev_last = wlast;
        if (awvalid && awready) begin
          if (aw_exp.size() == 0) check("aw_unexpected", awvalid, 0);
          else begin
            check("awaddr", awaddr, aw_exp.pop_front());
            check("awlen", awlen, cur_len);
            check("aw_size_burst", {awsize, awburst}, {3'd6, 2'd1});
            check("aw_side_zero", {awid, awlock, awcache, awprot}, 0);
          end
        end
        if (wvalid && wready) begin
          w_seen++;
          if (w_exp.size() == 0) check("w_unexpected", wvalid, 0);
          else begin
            bt = w_exp.pop_front();
            check("wdata", wdata, bt.data);
            check("wlast", wlast, bt.last);
            check("wstrb", wstrb, {(DW/8){1'b1}});
          end
          if (wlast) begin bq.push_back(wb_idx == bad_b ? 2'd2 : 2'd0); wb_idx++; end
        end
        if (arvalid && arready) begin
          if (ar_exp.size() == 0) check("ar_unexpected", arvalid, 0);
          else begin
            a = ar_exp.pop_front();
            check("araddr", araddr, a);
            check("arlen", arlen, cur_len);
            check("ar_size_burst", {arsize, arburst}, {3'd6, 2'd1});
            check("ar_side_zero", {arid, arlock, arcache, arprot}, 0);
            for (int i = 0; i <= int'(cur_len); i++) begin
              bt.data = pat(a + 64'(i * 64));
              if (r_idx == bad_r) bt.data[0] = ~bt.data[0];
              bt.last = (i == int'(cur_len));
              rq.push_back(bt);
              r_idx++;
            end
          end
        end
        if (done) begin
          if (fin_exp.size() == 0) check("done_unexpected", done, 0);
          else begin
            f = fin_exp.pop_front();
            check("err_count", err_count, f.err);
            check("b_handshakes", b_seen, f.nb);
          end
          wb_idx = 0; r_idx = 0; b_seen = 0; w_seen = 0;
        end
      end
    end
  end

  task automatic prep(input logic [63:0] base, input logic [7:0] len, input logic [15:0] cnt,
                      input bit rd, input int bb, input int br, input bit stl, input logic [15:0] eerr);
    fin_t f;
    beat_t bt;
    logic [63:0] a;
    bad_b = bb; bad_r = br; stall = stl; cur_len = len;
    for (int b = 0; b < int'(cnt); b++) begin
      a = base + 64'(b * (int'(len) + 1) * 64);
      aw_exp.push_back(a);
      if (rd) ar_exp.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
        bt.data = pat(a + 64'(i * 64)); bt.last = (i == int'(len));
        w_exp.push_back(bt);
      end
    end
    f.err = eerr; f.nb = int'(cnt);
    fin_exp.push_back(f);
    base_addr = base; burst_len = len; burst_count = cnt; do_read = rd;
  endtask

  task automatic run(input logic [63:0] base, input logic [7:0] len, input logic [15:0] cnt,
                     input bit rd, input int bb, input int br, input bit stl, input bit poke,
                     input logic [15:0] eerr);
    int cyc;
    @(negedge clk);
    prep(base, len, cnt, rd, bb, br, stl, eerr);
    start = 1;
    @(posedge clk); #1;
    start = 0; cyc = 1;
    check("busy_after_start", busy, 1);
    if (cnt != 0) check("aw_cycle_after_start", awvalid, 1);
    while (!done && cyc < 5000) begin
      if (poke && cyc == 3) begin start = 1; base_addr = '0; burst_count = 16'd1; end
      else start = 0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    check("done_seen", done, 1);
    if (cnt == 0) check("done_latency", cyc, 2);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("aw_left", aw_exp.size(), 0);
    check("w_left", w_exp.size(), 0);
    check("ar_left", ar_exp.size(), 0);
  endtask

  initial begin : stim
    int cyc;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_valids", {awvalid, wvalid, arvalid}, 0);
    check("rst_readies", {bready, rready}, 0);
    resetn = 1;
    @(negedge clk);
    check("bready_tied", bready, 1);

    run(64'h1000, 8'd3, 16'd2, 1, -1, -1, 0, 0, 16'd0);
    run(64'h2000, 8'd1, 16'd3, 0, 1, -1, 0, 0, 16'd1);
    run(64'h3000, 8'd3, 16'd1, 1, -1, 2, 0, 0, CORR_ERR);
    run(64'h0, 8'd3, 16'd0, 1, -1, -1, 0, 0, 16'd0);
    run(64'h4000, 8'd7, 16'd3, 1, -1, -1, 1, 1, 16'd0);
    run(64'hFFFF_FFFF_FFFF_FFC0, 8'd3, 16'd2, 1, -1, -1, 0, 0, 16'd0);

    // Abort a run in the middle of the third W beat.
    @(negedge clk);
    prep(64'h1000, 8'd3, 16'd2, 1, -1, -1, 0, 16'd0);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (w_seen < 2 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("w_beats_before_reset", w_seen, 2);
    resetn = 0;
    #1;
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_count, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    run(64'h1000, 8'd3, 16'd2, 1, -1, -1, 1, 0, 16'd0);

    repeat (4) @(posedge clk);
    #1;
    check("no_stray_done", fin_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
